// File: rtl/dp_bram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port block RAM.
// Holds the read-during-write mode enum and the byte-lane merge function.
package dp_bram_pkg;

  typedef enum logic [1:0] {
    READ_FIRST  = 2'd0,
    WRITE_FIRST = 2'd1,
    NO_CHANGE   = 2'd2
  } read_mode_e;

  // The merge works on a fixed wide word so one function serves every DATA_WIDTH;
  // callers size-cast in and out. DATA_WIDTH must not exceed MERGE_MAX_W.
  localparam int MERGE_MAX_W  = 512;
  localparam int MERGE_MAX_NB = MERGE_MAX_W / 8;

  function automatic logic [MERGE_MAX_W-1:0] merge_bytes(
    input logic [MERGE_MAX_W-1:0]  old_word,
    input logic [MERGE_MAX_W-1:0]  new_word,
    input logic [MERGE_MAX_NB-1:0] be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_MAX_NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dp_bram_out_pipe.sv
// Per-port read output path: RAM read register plus an optional second stage.
// Data only loads on a valid read, so the output holds its last value between reads.
module dp_bram_out_pipe
  import dp_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  vld
);

  logic [DATA_WIDTH-1:0] data_p0;
  logic                  vld_p0;

  // stage p0: RAM read register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= rd;
      if (rd) data_p0 <= rd_word;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] data_p1;
    logic                  vld_p1;

    // stage p1: optional output register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_p1 <= '0;
        vld_p1  <= 1'b0;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0) data_p1 <= data_p0;
      end
    end

    assign data = data_p1;
    assign vld  = vld_p1;
  end else begin : g_no_out_reg
    assign data = data_p0;
    assign vld  = vld_p0;
  end

endmodule

// File: rtl/dp_bram_be.sv
// Dual-port block RAM with per-byte write enables, selectable read-during-write
// behaviour, optional output register and a registered address-collision flag.
module dp_bram_be
  import dp_bram_pkg::*;
#(
  parameter int         ADDR_WIDTH = 16,
  parameter int         DATA_WIDTH = 32,
  parameter read_mode_e READ_MODE  = READ_FIRST,
  parameter int         OUT_REG    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [DATA_WIDTH/8-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]   addra,
  input  logic [DATA_WIDTH-1:0]   dia,
  output logic [DATA_WIDTH-1:0]   doa,
  output logic                    vala,
  input  logic                    enb,
  input  logic [DATA_WIDTH/8-1:0] web,
  input  logic [ADDR_WIDTH-1:0]   addrb,
  input  logic [DATA_WIDTH-1:0]   dib,
  output logic [DATA_WIDTH-1:0]   dob,
  output logic                    valb,
  output logic                    coll
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_a, wr_b, same_addr;
  logic                  rd_a, rd_b;
  logic [DATA_WIDTH-1:0] word_a, word_b;
  logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;

  assign wr_a      = ena && (wea != '0);
  assign wr_b      = enb && (web != '0);
  assign same_addr = (addra == addrb);

  // A NO_CHANGE port skips the read entirely whenever it writes.
  assign rd_a = ena && ((wea == '0) || (READ_MODE != NO_CHANGE));
  assign rd_b = enb && ((web == '0) || (READ_MODE != NO_CHANGE));

  // Both ports see the pre-edge contents, so a cross-port read always returns the old word.
  assign word_a = mem[addra];
  assign word_b = mem[addrb];

  assign rd_word_a = (READ_MODE == WRITE_FIRST)
                   ? DATA_WIDTH'(merge_bytes(MERGE_MAX_W'(word_a), MERGE_MAX_W'(dia), MERGE_MAX_NB'(wea)))
                   : word_a;
  assign rd_word_b = (READ_MODE == WRITE_FIRST)
                   ? DATA_WIDTH'(merge_bytes(MERGE_MAX_W'(word_b), MERGE_MAX_W'(dib), MERGE_MAX_NB'(web)))
                   : word_b;

  // RAM array: byte-lane writes; on a same-address clash port A owns the lanes it enables.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (enb && web[i] && !(ena && wea[i] && same_addr))
        mem[addrb][8*i +: 8] <= dib[8*i +: 8];
      if (ena && wea[i])
        mem[addra][8*i +: 8] <= dia[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coll <= 1'b0;
    else        coll <= ena && enb && same_addr && (wr_a || wr_b);
  end

  dp_bram_out_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_pipe_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd      (rd_a),
    .rd_word (rd_word_a),
    .data    (doa),
    .vld     (vala)
  );

  dp_bram_out_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_pipe_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd      (rd_b),
    .rd_word (rd_word_b),
    .data    (dob),
    .vld     (valb)
  );

endmodule
